// File: rtl/io_page_if.sv
// Processor-side memory bus for the IO page: address/store/read-strobe in,
// registered read data out.
interface io_page_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] io_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  io_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output io_rdata
  );
endinterface

// File: rtl/io_page.sv
// Memory-mapped IO page: LED register, 8N1 UART transmitter and optional cycle
// counter (enabled by defining IO_CYCLES_EN). Registers decode one-hot on addr[5:2].
module io_page #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  io_page_if.slave   bus,
  output logic [4:0] LEDS,
  output logic       TXD
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  uart_state_t    state, state_next;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shifter;
  logic           busy;
  logic           baud_done;
  logic           bit_last;
  logic [31:0]    io_rdata;
  logic [31:0]    rdata_next;

  logic is_io, leds_we, dat_we, tx_start, rd;

  assign is_io    = bus.mem_addr[22];
  assign leds_we  = is_io & bus.mem_addr[2] & bus.mem_wmask[0];
  assign dat_we   = is_io & bus.mem_addr[3] & bus.mem_wmask[0];
  assign tx_start = dat_we & (state == IDLE);
  assign rd       = is_io & bus.mem_rstrb;

  assign baud_done = (baud_cnt == '0);
  assign bit_last  = (bit_cnt == 3'd7);

`ifdef IO_CYCLES_EN
  logic [31:0] cycles;

  always_ff @(posedge clk) begin
    if (!resetn) cycles <= '0;
    else         cycles <= cycles + 32'd1;
  end

  logic unused_bits;
  assign unused_bits = ^{bus.mem_addr[31:23], bus.mem_addr[21:6], bus.mem_addr[1:0],
                         bus.mem_wdata[31:8], bus.mem_wmask[3:1]};
`else
  logic unused_bits;
  assign unused_bits = ^{bus.mem_addr[31:23], bus.mem_addr[21:5], bus.mem_addr[1:0],
                         bus.mem_wdata[31:8], bus.mem_wmask[3:1]};
`endif

  // UART FSM: state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // UART FSM: next state
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (tx_start)              state_next = START;
      START: if (baud_done)             state_next = DATA;
      DATA:  if (baud_done && bit_last) state_next = STOP;
      STOP:  if (baud_done)             state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // UART FSM: outputs
  always_comb begin
    busy = (state != IDLE);
    TXD  = 1'b1;
    unique case (state)
      IDLE:    TXD = 1'b1;
      START:   TXD = 1'b0;
      DATA:    TXD = shifter[0];
      STOP:    TXD = 1'b1;
      default: TXD = 1'b1;
    endcase
  end

  // Baud counter counts DIV-1 down to 0 in every non-idle state, so each bit
  // (start, data, stop) occupies exactly DIV cycles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
    end else if (state == IDLE) begin
      if (tx_start) begin
        shifter  <= bus.mem_wdata[7:0];
        baud_cnt <= RELOAD;
        bit_cnt  <= '0;
      end
    end else begin
      if (baud_done) begin
        baud_cnt <= RELOAD;
        if (state == DATA) begin
          shifter <= {1'b0, shifter[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - CW'(1);
      end
    end
  end

  always_comb begin
    rdata_next = '0;
    if (bus.mem_addr[2]) rdata_next = rdata_next | {27'b0, LEDS};
    if (bus.mem_addr[4]) rdata_next = rdata_next | {22'b0, busy, 9'b0};
`ifdef IO_CYCLES_EN
    if (bus.mem_addr[5]) rdata_next = rdata_next | cycles;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      LEDS     <= '0;
      io_rdata <= '0;
    end else begin
      if (leds_we) LEDS     <= bus.mem_wdata[4:0];
      if (rd)      io_rdata <= rdata_next;
    end
  end

  assign bus.io_rdata = io_rdata;

endmodule

// File: tb/tb_io_page.sv
// Self-checking bench for io_page at DIV=10: table of single-cycle bus vectors
// plus hand-written UART frame, drop, reset and cycle-counter sequences.
module tb_io_page;

  logic       clk;
  logic       resetn;
  logic [4:0] LEDS;
  logic       TXD;

  io_page_if bus();

  io_page #(
    .CLK_FREQ_HZ(1000000),
    .BAUD_RATE  (100000)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus),
    .LEDS  (LEDS),
    .TXD   (TXD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_leds;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wmask = 4'h0;
    bus.mem_rstrb = 1'b0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic r);
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wmask = m;
    bus.mem_rstrb = r;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode 0: plain frame; 1: 0x55 store at cycle 50 plus CNTL read mid-frame;
  // 2: store in the last STOP cycle; 3: reset at cycle 30.
  task automatic run_frame(input logic [7:0] d, input int mode, input string tag);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    drive(32'h0040_0008, {24'h0, d}, 4'b0001, 1'b0);
    for (int k = 0; k <= 100; k++) begin
      step();
      bus_idle();
      check($sformatf("%s txd[%0d]", tag, k), {31'b0, TXD},
            {31'b0, (k < 100) ? fr[k/10] : 1'b1});
      if (mode == 1 && k == 61)
        check({tag, " cntl mid-frame"}, bus.io_rdata, 32'h0000_0200);
      if (mode == 3 && k == 29) begin
        resetn = 1'b0;
        drive(32'h0040_0004, 32'h1F, 4'b0001, 1'b1);
        step();
        bus_idle();
        check({tag, " reset txd"},   {31'b0, TXD}, 32'h1);
        check({tag, " reset leds"},  {27'b0, LEDS}, 32'h0);
        check({tag, " reset rdata"}, bus.io_rdata, 32'h0);
        resetn = 1'b1;
        drive(32'h0040_0010, 32'h0, 4'h0, 1'b1);
        step();
        bus_idle();
        check({tag, " busy after reset"}, bus.io_rdata, 32'h0);
        return;
      end
      if (mode == 1 && k == 49) drive(32'h0040_0008, 32'h55, 4'b0001, 1'b0);
      if (mode == 1 && k == 60) drive(32'h0040_0010, 32'h0, 4'h0, 1'b1);
      if (mode == 2 && k == 99) drive(32'h0040_0008, 32'h7E, 4'b0001, 1'b0);
      if (k == 100) drive(32'h0040_0010, 32'h0, 4'h0, 1'b1);
    end
    step();
    bus_idle();
    check({tag, " busy after frame"}, bus.io_rdata, 32'h0);
    if (mode == 2) begin
      for (int k = 0; k < 20; k++) begin
        step();
        check($sformatf("%s no frame txd[%0d]", tag, k), {31'b0, TXD}, 32'h1);
      end
    end
  endtask

  initial begin
    logic [31:0] r1, r2;

    vecs.push_back('{32'h0040_0004, 32'h0000_001F, 4'b0001, 1'b0, 32'h00, 5'h1F});
    vecs.push_back('{32'h0040_0004, 32'h0,         4'b0000, 1'b1, 32'h1F, 5'h1F});
    vecs.push_back('{32'h0040_0008, 32'h0,         4'b0000, 1'b1, 32'h00, 5'h1F});
    vecs.push_back('{32'h0040_0004, 32'h0,         4'b0000, 1'b1, 32'h1F, 5'h1F});
    vecs.push_back('{32'h0000_0004, 32'h0,         4'b0000, 1'b1, 32'h1F, 5'h1F});
    vecs.push_back('{32'h0000_0004, 32'h0000_0003, 4'b0001, 1'b0, 32'h1F, 5'h1F});
    vecs.push_back('{32'h0040_0040, 32'h0,         4'b0000, 1'b1, 32'h00, 5'h1F});
    vecs.push_back('{32'h0040_0004, 32'h0,         4'b0000, 1'b1, 32'h1F, 5'h1F});
    vecs.push_back('{32'h0040_0004, 32'h0000_000A, 4'b0001, 1'b1, 32'h1F, 5'h0A});
    vecs.push_back('{32'h0040_0004, 32'h0,         4'b0000, 1'b1, 32'h0A, 5'h0A});
    vecs.push_back('{32'h0040_0004, 32'h0000_0015, 4'b1110, 1'b0, 32'h0A, 5'h0A});
    vecs.push_back('{32'h0040_0010, 32'h0,         4'b0000, 1'b1, 32'h00, 5'h0A});
    vecs.push_back('{32'h0040_0014, 32'h0,         4'b0000, 1'b1, 32'h0A, 5'h0A});
    vecs.push_back('{32'h0040_0004, 32'h0,         4'b0000, 1'b0, 32'h0A, 5'h0A});
    vecs.push_back('{32'h0040_000C, 32'h0,         4'b0000, 1'b1, 32'h0A, 5'h0A});
`ifndef IO_CYCLES_EN
    vecs.push_back('{32'h0040_0020, 32'h0,         4'b0000, 1'b1, 32'h00, 5'h0A});
    vecs.push_back('{32'h0040_0024, 32'h0,         4'b0000, 1'b1, 32'h0A, 5'h0A});
`endif

    resetn = 1'b0;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rdata", bus.io_rdata, 32'h0);
    check("reset leds", {27'b0, LEDS}, 32'h0);
    check("reset txd", {31'b0, TXD}, 32'h1);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].rstrb);
      step();
      bus_idle();
      check($sformatf("vec%0d rdata", i), bus.io_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d leds", i), {27'b0, LEDS}, {27'b0, vecs[i].exp_leds});
      check($sformatf("vec%0d txd", i), {31'b0, TXD}, 32'h1);
    end

    run_frame(8'h41, 0, "frame41");
    run_frame(8'h41, 1, "drop55");
    run_frame(8'hA6, 2, "stopdrop");

    drive(32'h0040_0004, 32'h0, 4'h0, 1'b1);
    step();
    bus_idle();
    check("leds before reset", bus.io_rdata, 32'h0A);
    run_frame(8'h41, 3, "rstframe");
    run_frame(8'h3C, 0, "after_rst");

`ifdef IO_CYCLES_EN
    drive(32'h0040_0020, 32'h0, 4'h0, 1'b1);
    step();
    bus_idle();
    r1 = bus.io_rdata;
    repeat (6) step();
    drive(32'h0040_0020, 32'h0, 4'h0, 1'b1);
    step();
    bus_idle();
    r2 = bus.io_rdata;
    check("cycles delta", r2 - r1, 32'd7);

    force dut.cycles = 32'hFFFF_FFFF;
    step();
    release dut.cycles;
    drive(32'h0040_0020, 32'h0, 4'h0, 1'b1);
    step();
    check("cycles max", bus.io_rdata, 32'hFFFF_FFFF);
    step();
    bus_idle();
    check("cycles wrap", bus.io_rdata, 32'h0);
`else
    r1 = 32'h0;
    r2 = 32'h0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/io_page.md
IO_PAGE -- requirements
Module: io_page

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 12000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, UART TX bit rate.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic SHALL sample on its rising edge.
REQ-004 The block SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port mem_addr  input  32  processor byte address.
REQ-006 The block SHALL have port mem_wdata  input  32  processor store data.
REQ-007 The block SHALL have port mem_wmask  input  4  byte write enables; nonzero means store.
REQ-008 The block SHALL have port mem_rstrb  input  1  read request.
REQ-009 The block SHALL have port io_rdata  output  32  registered read data.
REQ-010 The block SHALL have port LEDS  output  5  LED register.
REQ-011 The block SHALL have port TXD  output  1  UART serial out, idle high.

Function
REQ-012 The block SHALL treat an access as IO when mem_addr[22]=1; accesses with mem_addr[22]=0 SHALL have no effect and SHALL NOT change io_rdata.
REQ-013 The block SHALL decode registers one-hot on word-address bits: [2] LEDS, [3] UART_DAT, [4] UART_CNTL, [5] CYCLES.
REQ-014 On an IO store with mem_wmask[0]=1 and mem_addr[2]=1, the block SHALL set LEDS <= mem_wdata[4:0] at the next edge.
REQ-015 On an IO read with mem_rstrb=1, the block SHALL latch io_rdata at the next edge, giving 1-cycle latency; the value SHALL be the OR of every selected register.
REQ-016 LEDS SHALL read as {27'b0, LEDS}, UART_CNTL as {22'b0, busy, 9'b0}, and UART_DAT as 0.
REQ-017 An IO read with no register bit set SHALL return 0.
REQ-018 The baud divider SHALL be DIV = CLK_FREQ_HZ / BAUD_RATE, integer truncated, with DIV >= 2 required.
REQ-019 The UART SHALL use an FSM with states IDLE, START, DATA, STOP.
REQ-020 In IDLE, TXD=1 and busy=0; an IO store with mem_wmask[0]=1 and mem_addr[3]=1 SHALL latch mem_wdata[7:0] and enter START at the next edge.
REQ-021 START SHALL drive TXD=0 for DIV cycles.
REQ-022 DATA SHALL drive 8 bits LSB first, DIV cycles each.
REQ-023 STOP SHALL drive TXD=1 for DIV cycles, then return to IDLE.
REQ-024 A frame SHALL last exactly 10*DIV cycles; busy SHALL be 1 in START, DATA and STOP.
REQ-025 A UART_DAT store while busy=1 SHALL be dropped, with no queuing; this includes a store in the last STOP cycle.
REQ-026 The bit counter SHALL be 3 bits, and the baud counter SHALL be $clog2(DIV) bits, reloading at DIV-1.
REQ-027 A simultaneous IO read and store in the same cycle SHALL both be honoured; the read SHALL return pre-store values.

Reset
REQ-028 While resetn=0 at an edge, the block SHALL set LEDS=0, io_rdata=0, TXD=1, busy=0, FSM=IDLE and counters=0.
REQ-029 A reset mid-frame SHALL abort the frame, and TXD SHALL be 1 from the following edge.
REQ-030 Stores and reads presented while resetn=0 SHALL be ignored.

Configuration
REQ-031 With macro IO_CYCLES_EN defined, the block SHALL include a 32-bit free-running counter that increments every clk, resets to 0, wraps 0xFFFFFFFF->0, and reads via bit [5] as its value at the strobe edge.
REQ-032 With IO_CYCLES_EN undefined, the block SHALL contain no counter, and bit [5] SHALL read as 0.

Verification
(All scenarios use CLK_FREQ_HZ=1000000 and BAUD_RATE=100000, so DIV=10.)
REQ-033 The bench SHALL cover: store 0x0000001F, wmask 0001, addr 0x00400004 -> LEDS=5'h1F next edge; read same addr -> io_rdata=0x1F one cycle after strobe.
REQ-034 The bench SHALL cover: store 0x41 to 0x00400008 -> busy=1; TXD bit sequence 0,1,0,0,0,0,0,1,0,1, each 10 cycles; busy=0 after 100 cycles.
REQ-035 The bench SHALL cover: store 0x55 at cycle 50 of a 0x41 frame -> frame unchanged, 0x55 never transmitted; read 0x00400010 mid-frame -> 0x00000200.
REQ-036 The bench SHALL cover: resetn=0 at cycle 30 of a frame -> TXD=1, busy=0, LEDS=0 next edge; a new store then transmits normally.
REQ-037 The bench SHALL cover: read 0x00000004 (bit 22 clear) -> io_rdata and LEDS unchanged; read 0x00400040 -> 0.
REQ-038 The bench SHALL cover, with IO_CYCLES_EN: two reads of 0x00400020 exactly 7 cycles apart -> difference 7; force counter 0xFFFFFFFF -> reads 0 one cycle later.
